// File: rtl/async_fifo_drain.sv
// async_fifo_drain: read-domain FIFO consumer that presents popped words on a valid/ready port.
// Optional payload sequence checker is built when ASYNC_FIFO_DRAIN_CHECK_EN is defined.
module async_fifo_drain #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int ERR_W  = 8
) (
  input  logic              clk_read,
  input  logic              reset,
  input  logic              enable,
  input  logic              r_empty,
  input  logic [DATA_W-1:0] dout,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;
  logic   can_pop;

  assign can_pop = enable & ~r_empty;

  // A pop from HOLD only happens when the held word leaves in the same cycle.
  always_comb begin
    rd_en = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    rd_en = can_pop;
        HOLD:    rd_en = m_ready & can_pop;
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_read) begin
    if (reset) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_data   <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en) state <= FETCH;
        end
        FETCH: begin
          m_data  <= dout;
          m_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: begin
          if (m_ready) begin
            word_cnt <= word_cnt + 1'b1;
            m_valid  <= 1'b0;
            state    <= rd_en ? FETCH : IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASYNC_FIFO_DRAIN_CHECK_EN
  logic [DATA_W-1:0] expected;

  // Resynchronise to each observed word so a single glitch counts once.
  always_ff @(posedge clk_read) begin
    if (reset) begin
      expected <= '0;
      err_cnt  <= '0;
      seq_err  <= 1'b0;
    end else if (state == FETCH) begin
      expected <= dout + 1'b1;
      if (dout != expected) begin
        seq_err <= 1'b1;
        if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`else
  assign err_cnt = '0;
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_drain.sv
// tb_async_fifo_drain: randomized self-checking bench for async_fifo_drain against a
// transaction-level model of the pop/hold/accept protocol and the sequence checker.
module tb_async_fifo_drain;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 8;
`ifdef ASYNC_FIFO_DRAIN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk_read = 1'b0;
  logic              reset;
  logic              enable;
  logic              r_empty;
  logic [DATA_W-1:0] dout;
  logic              m_ready;
  logic              rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic [CNT_W-1:0]  word_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic              seq_err;

  always #5 clk_read = ~clk_read;

  async_fifo_drain #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk_read(clk_read),
    .reset(reset),
    .enable(enable),
    .r_empty(r_empty),
    .dout(dout),
    .rd_en(rd_en),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .word_cnt(word_cnt),
    .err_cnt(err_cnt),
    .seq_err(seq_err)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fifo_q[$];

  // Model view: a word is either in flight (popped, not yet shown), held on the port, or absent.
  bit         mdl_inflight;
  bit         mdl_valid;
  logic [7:0] mdl_word;
  logic [7:0] mdl_data;
  logic [7:0] mdl_next;
  int         mdl_cnt;
  int         mdl_err;
  bit         mdl_seq;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mdl_inflight = 1'b0;
    mdl_valid    = 1'b0;
    mdl_data     = 8'h00;
    mdl_next     = 8'h00;
    mdl_cnt      = 0;
    mdl_err      = 0;
    mdl_seq      = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model, let the rising edge act.
  task automatic applyStimulus(input bit rst, input bit en, input bit rdy);
    bit exp_rd;
    reset   = rst;
    enable  = en;
    m_ready = rdy;
    r_empty = (fifo_q.size() == 0);
    #1;
    exp_rd = !rst && en && !r_empty && !mdl_inflight && (!mdl_valid || rdy);
    checkOutput("rd_en", 32'(rd_en), 32'(exp_rd));
    checkOutput("m_valid", 32'(m_valid), 32'(mdl_valid));
    if (mdl_valid) checkOutput("m_data", 32'(m_data), 32'(mdl_data));
    checkOutput("word_cnt", 32'(word_cnt), 32'(mdl_cnt));
    checkOutput("err_cnt", 32'(err_cnt), 32'(mdl_err));
    checkOutput("seq_err", 32'(seq_err), 32'(mdl_seq));
    if (rst) begin
      modelReset();
    end else begin
      if (mdl_valid && rdy) begin
        mdl_cnt   = (mdl_cnt + 1) % (1 << CNT_W);
        mdl_valid = 1'b0;
      end
      if (mdl_inflight) begin
        mdl_valid    = 1'b1;
        mdl_data     = mdl_word;
        mdl_inflight = 1'b0;
        if (mdl_word != mdl_next && CHK) begin
          mdl_seq = 1'b1;
          if (mdl_err < (1 << ERR_W) - 1) mdl_err++;
        end
        mdl_next = mdl_word + 8'd1;
      end
      if (exp_rd) begin
        mdl_inflight = 1'b1;
        mdl_word     = fifo_q.pop_front();
      end
    end
    @(posedge clk_read);
    @(negedge clk_read);
    if (exp_rd) dout = mdl_word;
  endtask

  task automatic runUntilIdle(input int budget, input bit rnd);
    int n = 0;
    bit en, rdy;
    while ((fifo_q.size() != 0 || mdl_inflight || mdl_valid) && n < budget) begin
      en  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      applyStimulus(1'b0, en, rdy);
      n++;
    end
    checkOutput("drain_done", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    enable  = 1'b1;
    m_ready = 1'b1;
    r_empty = 1'b1;
    dout    = 8'h00;
    modelReset();
    repeat (2) @(negedge clk_read);

    // Reset held with a non-empty FIFO: no pops, then first pop right after release.
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(i));
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1);

    n = 0;
    while (mdl_cnt < 20 && n < 100) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      n++;
    end
    checkOutput("stream_cnt", 32'(word_cnt), 32'd20);
    checkOutput("stream_err", 32'(err_cnt), 32'd0);

    // Backpressure: hold the first new word for 10 cycles while more data waits.
    fifo_q.push_back(8'h14);
    fifo_q.push_back(8'h15);
    n = 0;
    while (!mdl_valid && n < 10) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      n++;
    end
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bp_data", 32'(m_data), 32'h14);
    runUntilIdle(50, 1'b0);

    // Long in-order run ending with the FF->00 wrap and a single out-of-sequence word.
    for (int i = 8'h16; i <= 8'hFD; i++) fifo_q.push_back(8'(i));
    fifo_q.push_back(8'hFE);
    fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h06);
    runUntilIdle(3000, 1'b1);
    checkOutput("wrap_err", 32'(err_cnt), CHK ? 32'd1 : 32'd0);
    checkOutput("wrap_seq", 32'(seq_err), 32'(CHK));

    // Enable drops while a word is in flight: it completes, no further pop.
    fifo_q.push_back(8'h07);
    fifo_q.push_back(8'h08);
    n = 0;
    while (!mdl_inflight && n < 10) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      n++;
    end
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    runUntilIdle(20, 1'b0);

    // Reset during HOLD drops the held word.
    fifo_q.push_back(8'h09);
    n = 0;
    while (!mdl_valid && n < 10) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("rst_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_cnt", 32'(word_cnt), 32'd0);

    // Saturation: every word breaks the sequence.
    for (int i = 0; i < 300; i++) fifo_q.push_back(8'h55);
    runUntilIdle(5000, 1'b1);
    checkOutput("sat_err", 32'(err_cnt), CHK ? 32'd255 : 32'd0);
    checkOutput("sat_seq", 32'(seq_err), 32'(CHK));
    checkOutput("sat_cnt", 32'(word_cnt), 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
